stage_link: RTL and testbench
=============================

STAGE_LINK -- requirements
Module: stage_link

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the payload bus carried between pipeline stages.
REQ-002 Parameter DEPTH, default 2: number of payload entries buffered; legal values 1, 2, 4, 8.
REQ-003 Parameter MULTICYCLE, default 0: 0 = pipelined link; 1 = one-in-flight link gated by a downstream completion pulse.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately regardless of clk.
REQ-006 in_bus  in  DATA_WIDTH  payload from the upstream stage.
REQ-007 in_valid  in  1  upstream offers in_bus this cycle.
REQ-008 in_ready  out  1  link accepts in_bus this cycle.
REQ-009 out_bus  out  DATA_WIDTH  oldest buffered payload.
REQ-010 out_valid  out  1  out_bus holds a valid entry.
REQ-011 out_ready  in  1  downstream consumes out_bus this cycle.
REQ-012 flush  in  1  synchronous discard of all buffered entries and of the in-flight token.
REQ-013 done  in  1  one-cycle completion pulse from the final stage (used only when MULTICYCLE=1).
REQ-014 count  out  $clog2(DEPTH+1)  number of entries currently buffered.

Function
REQ-015 Push occurs in a cycle with in_valid=1 and in_ready=1; pop occurs in a cycle with out_valid=1 and out_ready=1.
REQ-016 Storage is DEPTH entries addressed by write and read pointers that wrap modulo DEPTH.
REQ-017 out_valid SHALL equal (count != 0); out_bus SHALL equal the entry at the read pointer, driven from registers only.
REQ-018 in_ready SHALL equal (count < DEPTH) AND NOT flush AND (MULTICYCLE=0 OR NOT busy); in_ready has no combinational dependence on out_ready or in_valid.
REQ-019 Latency: a payload pushed at edge N SHALL appear on out_bus with out_valid=1 in the cycle following edge N when the link was empty.
REQ-020 Ordering: payloads SHALL leave in the order accepted; none duplicated or dropped absent flush.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-022 Full (count=DEPTH): in_ready=0 even if out_ready=1 that cycle; push resumes the cycle after a pop.
REQ-023 Empty: out_valid=0, out_ready ignored, count and read pointer unchanged.
REQ-024 flush=1 at an edge: count, both pointers and busy SHALL be 0 after that edge; flush overrides any concurrent push, pop or done.
REQ-025 MULTICYCLE=1: busy register set at an edge with a push, cleared at an edge with done=1; push and done in the same cycle leave busy=1.
REQ-026 MULTICYCLE=1: done=1 while busy=0 SHALL be ignored.
REQ-027 MULTICYCLE=0: busy held at 0 and done ignored.
REQ-028 out_bus content when out_valid=0 is don't-care but SHALL not contain X after reset (storage reset to 0).

Reset
REQ-029 While rst=0: count=0, pointers=0, busy=0, out_valid=0, all storage entries 0, out_bus=0; in_ready=0.
REQ-030 Reset assertion mid-transfer discards all entries asynchronously; first push accepted at the first rising edge after rst returns to 1 with in_valid=1.

Verification
REQ-031 DEPTH=2, MULTICYCLE=0: push 0x11111111 at edge 1 with out_ready=0 -> cycle after edge 1: out_valid=1, out_bus=0x11111111, count=1.
REQ-032 DEPTH=2: push 0xA, 0xB with out_ready=0, then hold in_valid=1 with 0xC -> count=2, in_ready=0; raise out_ready one cycle -> 0xA popped, 0xC accepted on the following edge, order 0xB,0xC.
REQ-033 DEPTH=4: continuous in_valid=1/out_ready=1 for 10 cycles with payloads 1..10 -> count stays 1 after first push, outputs 1..10 in order, pointers wrap twice without loss.
REQ-034 DEPTH=2, count=2, flush=1 with in_valid=1 and out_ready=1 same cycle -> after edge count=0, out_valid=0, no payload accepted.
REQ-035 MULTICYCLE=1: push 0x5 -> in_ready=0 until done pulses; done and next push (0x6) same cycle -> busy stays 1, in_ready=0 next cycle; done while busy=0 -> no effect.
REQ-036 rst driven 0 between edges with count=2 -> count=0, out_valid=0 immediately, before next clk edge.

Source files
------------

// File: rtl/stage_link.sv
// stage_link: DEPTH-entry valid/ready buffer between two pipeline stages, optional one-in-flight gating.
// Latency: a payload pushed into an empty link is on out_bus with out_valid=1 in the cycle after the push edge.
// Backpressure: in_ready = not full, no flush, and (MULTICYCLE=0 or no token in flight); it never depends on out_ready or in_valid.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   in_bus/in_valid   upstream payload offer; in_ready accepts it
//   out_bus/out_valid oldest buffered payload; out_ready consumes it
//   flush             synchronous discard of every entry and of the in-flight token
//   done              completion pulse from the final stage (MULTICYCLE=1 only)
//   count             number of buffered entries
// DEPTH must be 1, 2, 4 or 8 so that the pointers wrap cleanly.

module stage_link #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int MULTICYCLE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_bus,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_bus,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  input  logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  // A one-entry link still gets a 1-bit pointer; it simply never leaves 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  busy_q,   busy_d;
  logic                  push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  // rst is folded in so the link reports not-ready while it is held in reset.
  assign in_ready  = rst && (count_q < CW'(DEPTH)) && !flush &&
                     ((MULTICYCLE == 0) || !busy_q);
  assign out_valid = (count_q != '0);
  assign out_bus   = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Push wins over done so a completion arriving with the next token keeps the
  // link occupied; done with nothing in flight is a no-op.
  always_comb begin
    busy_d = busy_q;
    if (flush)     busy_d = 1'b0;
    else if (push) busy_d = 1'b1;
    else if (done) busy_d = 1'b0;
    if (MULTICYCLE == 0) busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Storage is cleared on reset so out_bus is never X, even while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_bus;
    end
  end

endmodule

// File: tb/tb_stage_link.sv
module tb_stage_link;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // u2: DEPTH=2, pipelined
  logic [31:0] a_in_bus = '0, a_out_bus;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_flush = 0, a_done = 0;
  logic [1:0] a_count;
  // u4: DEPTH=4, pipelined
  logic [31:0] b_in_bus = '0, b_out_bus;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_flush = 0, b_done = 0;
  logic [2:0] b_count;
  // um: DEPTH=2, one in flight
  logic [31:0] c_in_bus = '0, c_out_bus;
  logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_flush = 0, c_done = 0;
  logic [1:0] c_count;

  stage_link #(.DATA_WIDTH(32), .DEPTH(2), .MULTICYCLE(0)) u2 (
    .clk(clk), .rst(rst), .in_bus(a_in_bus), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_bus(a_out_bus), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .flush(a_flush), .done(a_done), .count(a_count));

  stage_link #(.DATA_WIDTH(32), .DEPTH(4), .MULTICYCLE(0)) u4 (
    .clk(clk), .rst(rst), .in_bus(b_in_bus), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_bus(b_out_bus), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .flush(b_flush), .done(b_done), .count(b_count));

  stage_link #(.DATA_WIDTH(32), .DEPTH(2), .MULTICYCLE(1)) um (
    .clk(clk), .rst(rst), .in_bus(c_in_bus), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_bus(c_out_bus), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .flush(c_flush), .done(c_done), .count(c_count));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #3;
    chk("rst_a_count",     64'(a_count), 0);
    chk("rst_a_out_valid", 64'(a_out_valid), 0);
    chk("rst_a_out_bus",   64'(a_out_bus), 0);
    chk("rst_a_in_ready",  64'(a_in_ready), 0);
    chk("rst_b_count",     64'(b_count), 0);
    chk("rst_c_in_ready",  64'(c_in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- first push latency ----------------
    a_in_valid = 1; a_in_bus = 32'h11111111;
    #1;
    chk("lat_in_ready", 64'(a_in_ready), 1);
    tick();
    a_in_valid = 0;
    chk("lat_out_valid", 64'(a_out_valid), 1);
    chk("lat_out_bus",   64'(a_out_bus), 64'h11111111);
    chk("lat_count",     64'(a_count), 1);
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    chk("drain_count", 64'(a_count), 0);

    // ---------------- full / backpressure / order ----------------
    a_in_valid = 1; a_in_bus = 32'hA;
    tick();
    a_in_bus = 32'hB;
    tick();
    a_in_bus = 32'hC;
    #1;
    chk("full_count",    64'(a_count), 2);
    chk("full_in_ready", 64'(a_in_ready), 0);
    chk("full_out_bus",  64'(a_out_bus), 64'hA);
    a_out_ready = 1;
    #1;
    chk("full_rdy_in_ready", 64'(a_in_ready), 0);
    tick();
    a_out_ready = 0;
    chk("pop_a_count",    64'(a_count), 1);
    chk("pop_a_out_bus",  64'(a_out_bus), 64'hB);
    chk("pop_a_in_ready", 64'(a_in_ready), 1);
    tick();
    a_in_valid = 0;
    chk("push_c_count",   64'(a_count), 2);
    chk("push_c_out_bus", 64'(a_out_bus), 64'hB);
    a_out_ready = 1;
    tick();
    chk("order_c_out_bus", 64'(a_out_bus), 64'hC);
    chk("order_c_count",   64'(a_count), 1);
    tick();
    chk("empty_out_valid", 64'(a_out_valid), 0);
    tick();
    chk("empty_rdy_count", 64'(a_count), 0);
    a_out_ready = 0;

    // ---------------- flush overrides push and pop ----------------
    a_in_valid = 1; a_in_bus = 32'h21;
    tick();
    a_in_bus = 32'h22;
    tick();
    chk("pre_flush_count", 64'(a_count), 2);
    a_flush = 1; a_in_bus = 32'h23; a_out_ready = 1;
    #1;
    chk("flush_in_ready", 64'(a_in_ready), 0);
    tick();
    a_flush = 0; a_in_bus = 32'h24; a_out_ready = 0;
    chk("flush_count",     64'(a_count), 0);
    chk("flush_out_valid", 64'(a_out_valid), 0);
    tick();
    a_in_valid = 0;
    chk("post_flush_bus",   64'(a_out_bus), 64'h24);
    chk("post_flush_count", 64'(a_count), 1);
    a_in_valid = 1; a_in_bus = 32'h25;
    tick();
    a_in_valid = 0;
    chk("pre_rst_count", 64'(a_count), 2);

    // ---------------- asynchronous reset between edges ----------------
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count",     64'(a_count), 0);
    chk("arst_out_valid", 64'(a_out_valid), 0);
    chk("arst_out_bus",   64'(a_out_bus), 0);
    chk("arst_in_ready",  64'(a_in_ready), 0);
    rst = 1'b1;
    a_in_valid = 1; a_in_bus = 32'h41;
    tick();
    a_in_valid = 0;
    chk("arst_first_bus",   64'(a_out_bus), 64'h41);
    chk("arst_first_count", 64'(a_count), 1);

    // ---------------- DEPTH=4 streaming, pointers wrap ----------------
    b_in_valid = 1; b_out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      b_in_bus = 32'(i);
      tick();
      chk("stream_count", 64'(b_count), 1);
      chk("stream_bus",   64'(b_out_bus), 64'(i));
    end
    chk("stream_in_ready", 64'(b_in_ready), 1);
    b_in_valid = 0;
    tick();
    b_out_ready = 0;
    chk("stream_end_count", 64'(b_count), 0);
    chk("stream_end_valid", 64'(b_out_valid), 0);

    // ---------------- MULTICYCLE=1 token gating ----------------
    c_in_valid = 1; c_in_bus = 32'h5;
    #1;
    chk("mc_ready0", 64'(c_in_ready), 1);
    tick();
    c_in_bus = 32'h6;
    chk("mc_busy_ready", 64'(c_in_ready), 0);
    chk("mc_out_bus5",   64'(c_out_bus), 64'h5);
    tick();
    chk("mc_blocked_count", 64'(c_count), 1);
    c_out_ready = 1;
    tick();
    c_out_ready = 0;
    chk("mc_popped_count", 64'(c_count), 0);
    chk("mc_popped_ready", 64'(c_in_ready), 0);
    c_done = 1;
    tick();
    c_done = 0;
    chk("mc_done_ready", 64'(c_in_ready), 1);
    c_done = 1;
    tick();
    c_done = 0; c_in_valid = 0;
    chk("mc_push_done_ready", 64'(c_in_ready), 0);
    chk("mc_push_done_count", 64'(c_count), 1);
    chk("mc_out_bus6",        64'(c_out_bus), 64'h6);
    chk("mc_out_valid6",      64'(c_out_valid), 1);
    c_out_ready = 1;
    tick();
    c_out_ready = 0;
    c_done = 1;
    tick();
    c_done = 0;
    chk("mc_idle_ready", 64'(c_in_ready), 1);
    c_done = 1;
    tick();
    c_done = 0;
    chk("mc_spurious_done_ready", 64'(c_in_ready), 1);
    chk("mc_spurious_done_count", 64'(c_count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
